// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter: the driver holds the master side, the counter the slave side.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_enable;
  logic             i_up;
  logic [WIDTH-1:0] o_count;
  logic             o_tc;
  logic             o_overflow;

  modport master (
    output i_clear, i_load, i_load_val, i_enable, i_up,
    input  o_count, o_tc, o_overflow
  );

  modport slave (
    input  i_clear, i_load, i_load_val, i_enable, i_up,
    output o_count, o_tc, o_overflow
  );
endinterface

// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, wrap/saturate limit handling,
// registered terminal-count pulse and sticky overflow flag.
module mod_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MODULUS  = 256,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  mod_counter_if.slave bus
);

  localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0] MAX_C    = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   ld_ext;

  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    step    = 1'b0;
    cnt_ext = {1'b0, count_q};
    ld_ext  = {1'b0, bus.i_load_val};

    if (bus.i_clear) begin
      count_d = '0;
      pre_d   = '0;
      ovf_d   = 1'b0;
    end else if (bus.i_load) begin
      pre_d = '0;
      if (ld_ext > MAX_C) begin
        count_d = MAX_C[WIDTH-1:0];
      end else begin
        count_d = bus.i_load_val;
      end
    end else if (bus.i_enable) begin
      if (pre_q == PRE_LAST) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end

    // Limit handling shared by both directions: flag, then wrap or hold.
    if (step) begin
      if (bus.i_up) begin
        if (cnt_ext == MAX_C) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end else begin
          count_d = WIDTH'(cnt_ext + 1'b1);
        end
      end else begin
        if (cnt_ext == '0) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
          if (SATURATE == 0) count_d = MAX_C[WIDTH-1:0];
        end else begin
          count_d = WIDTH'(cnt_ext - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
      pre_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_count    = count_q;
  assign bus.o_tc       = tc_q;
  assign bus.o_overflow = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Drives four differently parameterised mod_counter instances with common
// stimulus and compares each against a per-instance arithmetic model.
module tb_mod_counter;

  localparam int N = 4;
  localparam int MODS [N] = '{256, 10, 10, 100};
  localparam int PSS  [N] = '{1, 3, 1, 2};
  localparam int SATS [N] = '{0, 0, 1, 0};

  typedef struct {
    int cnt;
    int pre;
    bit tc;
    bit ov;
  } st_t;

  logic       clk;
  logic       rst_n;
  logic       clr, ld, en, up;
  logic [7:0] ldv;

  logic [7:0] obs_cnt [N];
  logic       obs_tc  [N];
  logic       obs_ov  [N];

  st_t model [N];
  int  errors;
  int  checks;

  mod_counter_if #(.WIDTH(8)) bus0 ();
  mod_counter_if #(.WIDTH(8)) bus1 ();
  mod_counter_if #(.WIDTH(8)) bus2 ();
  mod_counter_if #(.WIDTH(8)) bus3 ();

  assign bus0.i_clear = clr; assign bus0.i_load = ld; assign bus0.i_load_val = ldv;
  assign bus0.i_enable = en; assign bus0.i_up = up;
  assign bus1.i_clear = clr; assign bus1.i_load = ld; assign bus1.i_load_val = ldv;
  assign bus1.i_enable = en; assign bus1.i_up = up;
  assign bus2.i_clear = clr; assign bus2.i_load = ld; assign bus2.i_load_val = ldv;
  assign bus2.i_enable = en; assign bus2.i_up = up;
  assign bus3.i_clear = clr; assign bus3.i_load = ld; assign bus3.i_load_val = ldv;
  assign bus3.i_enable = en; assign bus3.i_up = up;

  assign obs_cnt[0] = bus0.o_count; assign obs_tc[0] = bus0.o_tc; assign obs_ov[0] = bus0.o_overflow;
  assign obs_cnt[1] = bus1.o_count; assign obs_tc[1] = bus1.o_tc; assign obs_ov[1] = bus1.o_overflow;
  assign obs_cnt[2] = bus2.o_count; assign obs_tc[2] = bus2.o_tc; assign obs_ov[2] = bus2.o_overflow;
  assign obs_cnt[3] = bus3.o_count; assign obs_tc[3] = bus3.o_tc; assign obs_ov[3] = bus3.o_overflow;

  mod_counter #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus0));
  mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus1));
  mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus2));
  mod_counter #(.WIDTH(8), .MODULUS(100), .PRESCALE(2), .SATURATE(0)) dut3 (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter behaviour expressed directly from the rules: priority, prescale, limits.
  function automatic st_t ref_next(st_t s, int m, int p, int sat);
    st_t n;
    bit  stepping;
    n        = s;
    n.tc     = 1'b0;
    stepping = 1'b0;
    if (clr) begin
      n = '{0, 0, 1'b0, 1'b0};
    end else if (ld) begin
      n.cnt = (int'(ldv) > m - 1) ? m - 1 : int'(ldv);
      n.pre = 0;
    end else if (en) begin
      if (s.pre == p - 1) begin
        n.pre    = 0;
        stepping = 1'b1;
      end else begin
        n.pre = s.pre + 1;
      end
    end
    if (stepping) begin
      if (up) begin
        if (s.cnt == m - 1) begin
          n.tc = 1'b1; n.ov = 1'b1;
          n.cnt = (sat != 0) ? s.cnt : 0;
        end else begin
          n.cnt = s.cnt + 1;
        end
      end else begin
        if (s.cnt == 0) begin
          n.tc = 1'b1; n.ov = 1'b1;
          n.cnt = (sat != 0) ? 0 : m - 1;
        end else begin
          n.cnt = s.cnt - 1;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s[%0d].count", tag, i), 32'(obs_cnt[i]), 32'(model[i].cnt));
      chk($sformatf("%s[%0d].tc", tag, i), 32'(obs_tc[i]), 32'(model[i].tc));
      chk($sformatf("%s[%0d].ovf", tag, i), 32'(obs_ov[i]), 32'(model[i].ov));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = '{0, 0, 1'b0, 1'b0};
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (rst_n) model[i] = ref_next(model[i], MODS[i], PSS[i], SATS[i]);
    end
    check_all(tag);
  endtask

  int exp_sat_cnt [5] = '{1, 0, 0, 0, 0};
  bit exp_sat_tc  [5] = '{0, 0, 1, 1, 1};

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clr = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b1; ldv = '0;
    model_reset();

    tick("reset");
    tick("reset");
    #3 rst_n = 1'b1;

    // Free run on defaults; modulus-10 prescale-3 instance runs alongside.
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      tick("run");
      if (k == 29)  chk("b_before_wrap", 32'(obs_cnt[1]), 32'd9);
      if (k == 30) begin
        chk("b_wrap_count", 32'(obs_cnt[1]), 32'd0);
        chk("b_wrap_tc", 32'(obs_tc[1]), 32'd1);
      end
      if (k == 255) begin
        chk("a_top_count", 32'(obs_cnt[0]), 32'd255);
        chk("a_top_ovf", 32'(obs_ov[0]), 32'd0);
      end
      if (k == 256) begin
        chk("a_wrap_count", 32'(obs_cnt[0]), 32'd0);
        chk("a_wrap_tc", 32'(obs_tc[0]), 32'd1);
        chk("a_wrap_ovf", 32'(obs_ov[0]), 32'd1);
      end
      if (k == 257) chk("a_tc_single", 32'(obs_tc[0]), 32'd0);
    end

    clr = 1'b1;
    tick("clear");
    clr = 1'b0;

    // Saturating down-count from 2.
    ld = 1'b1; ldv = 8'd2; en = 1'b0;
    tick("load2");
    ld = 1'b0; en = 1'b1; up = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick("satdown");
      chk($sformatf("c_sat_count%0d", k), 32'(obs_cnt[2]), 32'(exp_sat_cnt[k]));
      chk($sformatf("c_sat_tc%0d", k), 32'(obs_tc[2]), 32'(exp_sat_tc[k]));
    end

    // Over-range load with enable held: clamps and resets prescaler.
    ld = 1'b1; ldv = 8'd200; en = 1'b1; up = 1'b1;
    tick("loadclamp");
    chk("d_clamp", 32'(obs_cnt[3]), 32'd99);
    chk("a_load200", 32'(obs_cnt[0]), 32'd200);
    ld = 1'b0;
    tick("postload");
    chk("d_prescale_hold", 32'(obs_cnt[3]), 32'd99);
    tick("postload");
    chk("d_wrap_count", 32'(obs_cnt[3]), 32'd0);
    chk("d_wrap_tc", 32'(obs_tc[3]), 32'd1);

    clr = 1'b1; ld = 1'b1; ldv = 8'd5;
    tick("clrload");
    for (int i = 0; i < N; i++) begin
      chk($sformatf("clrload_count%0d", i), 32'(obs_cnt[i]), 32'd0);
      chk($sformatf("clrload_ovf%0d", i), 32'(obs_ov[i]), 32'd0);
    end
    clr = 1'b0; ld = 1'b0;

    for (int k = 0; k < 400; k++) begin
      clr = ($urandom_range(0, 31) == 0);
      ld  = ($urandom_range(0, 15) == 0);
      ldv = 8'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      up  = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    // Asynchronous reset in mid-count.
    clr = 1'b1; ld = 1'b0; en = 1'b1; up = 1'b1;
    tick("preclr");
    clr = 1'b0;
    for (int k = 0; k < 37; k++) tick("to37");
    chk("a_at37", 32'(obs_cnt[0]), 32'd37);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("async_count%0d", i), 32'(obs_cnt[i]), 32'd0);
      chk($sformatf("async_tc%0d", i), 32'(obs_tc[i]), 32'd0);
      chk($sformatf("async_ovf%0d", i), 32'(obs_ov[i]), 32'd0);
    end
    tick("inreset");
    #3 rst_n = 1'b1;
    tick("resume");
    chk("a_resume", 32'(obs_cnt[0]), 32'd1);
    for (int k = 0; k < 5; k++) tick("resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
Parametrised successor to the free-running counter. Adds modulus, up/down direction, synchronous clear and load, a step prescaler, and a selectable wrap or saturate mode. Outputs a registered terminal-count pulse and a sticky overflow flag. Used as a general timebase and event counter across the design.

Parameters:
WIDTH, 8, counter width in bits.
MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2**WIDTH.
PRESCALE, 1, number of qualifying enables per count step; legal range >=1.
SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
i_clk  in  1  clock; all state updates on its rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_clear  in  1  synchronous clear of count, prescaler and flags.
i_load  in  1  synchronous load of i_load_val.
i_load_val  in  WIDTH  value to load.
i_enable  in  1  counting qualifier.
i_up  in  1  direction: 1 = increment, 0 = decrement.
o_count  out  WIDTH  current count.
o_tc  out  1  registered one-cycle terminal-count pulse.
o_overflow  out  1  sticky flag, set on any wrap or saturation event.

Behaviour:
- Reset (i_reset_n=0, asynchronous): o_count=0, o_tc=0, o_overflow=0, prescaler=0. Holds while i_reset_n is low. First update occurs on the first rising edge after release.
- Per-edge priority: i_clear > i_load > step.
- Clear: o_count=0, prescaler=0, o_overflow=0, o_tc=0.
- Load: o_count=min(i_load_val, MODULUS-1). Prescaler=0, o_tc=0, o_overflow unchanged. A simultaneous i_enable is ignored.
- Prescaler: internal counter of ceil(log2(PRESCALE)) bits, minimum 1 bit.
  - Advances on each edge where i_enable=1 and no clear or load occurs.
  - A step fires on the enable that finds prescaler==PRESCALE-1; prescaler then returns to 0.
  - PRESCALE=1: every enable steps.
  - i_enable=0: prescaler holds.
- Step, up direction:
  - count<MODULUS-1: count+1.
  - count==MODULUS-1 and SATURATE=0: count=0, o_tc=1, o_overflow=1.
  - count==MODULUS-1 and SATURATE=1: count holds, o_tc=1, o_overflow=1.
- Step, down direction:
  - count>0: count-1.
  - count==0 and SATURATE=0: count=MODULUS-1, o_tc=1, o_overflow=1.
  - count==0 and SATURATE=1: count holds, o_tc=1, o_overflow=1.
- o_tc is high for exactly the one cycle following the edge that produced the wrap or saturation event. It is 0 on every other edge, including enabled edges that did not step.
- In saturate mode, o_tc repeats on every further attempted step at the limit.
- i_up is sampled only on edges where a step occurs. Direction may change on any cycle with no penalty.
- Arithmetic is performed in WIDTH+1 bits, so no internal overflow occurs when MODULUS=2**WIDTH.
- Latency: count, o_tc and o_overflow all update on the same edge that qualifies the event (one register stage, no combinational outputs).
- Reset assertion mid-count aborts immediately. No pending step survives reset.

Test Plan:
- Defaults, hold i_enable=1 for 260 cycles after reset release -> count 0..255, then 0 at cycle 256. o_tc high in the cycle count reads 0 after 255. o_overflow=1 from then on.
- MODULUS=10, PRESCALE=3, i_enable=1 -> count steps every 3 cycles through 0..9, wraps to 0. o_tc pulses once per 30 cycles.
- MODULUS=10, SATURATE=1, i_up=0 from count=2, 5 steps -> count 1, 0, 0, 0, 0. o_tc high after steps 3, 4 and 5.
- Assert i_load=1 with i_load_val=200 (MODULUS=100) together with i_enable=1 -> count=99, prescaler=0, no step. Next up step wraps to 0 with an o_tc pulse.
- Assert i_clear and i_load together with i_load_val=5 -> count=0 and o_overflow cleared.
- Drop i_reset_n mid-count at count=37 (asynchronous, between edges) -> o_count=0, o_tc=0, o_overflow=0 immediately. Counting resumes from 0 at the first edge after release.
